// File: rtl/execute_stage_if.sv
// Signal bundle around the Y86-64 execute stage: decode-side inputs, stall controls,
// combinational forwarding outputs and the registered M-stage outputs.
interface execute_stage_if;
  logic [3:0]  D_icode;
  logic [3:0]  D_ifun;
  logic [63:0] D_valA;
  logic [63:0] D_valB;
  logic [63:0] D_valC;
  logic [3:0]  D_dstE;
  logic [3:0]  D_dstM;
  logic        E_bubble;
  logic        M_bubble;
  logic        cc_hold;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [2:0]  cc;

  modport slave (
    input  D_icode, D_ifun, D_valA, D_valB, D_valC, D_dstE, D_dstM,
    input  E_bubble, M_bubble, cc_hold,
    output e_valE, e_dstE, e_Cnd,
    output M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc
  );

  modport master (
    output D_icode, D_ifun, D_valA, D_valB, D_valC, D_dstE, D_dstM,
    output E_bubble, M_bubble, cc_hold,
    input  e_valE, e_dstE, e_Cnd,
    input  M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc
  );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E register, ALU operand/function select, condition codes,
// branch/cmov condition evaluation and the M register feeding the memory stage.
module execute_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic           clk,
  input  logic           rst_n,
  execute_stage_if.slave bus
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_XOR = 4'h3;

  localparam logic [W-1:0] STACK_INC = W'(8);
  localparam logic [W-1:0] STACK_DEC = ~STACK_INC + W'(1);

  // E pipeline register
  logic [3:0]   e_icode_reg;
  logic [3:0]   e_ifun_reg;
  logic [W-1:0] e_val_a_reg;
  logic [W-1:0] e_val_b_reg;
  logic [W-1:0] e_val_c_reg;
  logic [3:0]   e_dst_e_reg;
  logic [3:0]   e_dst_m_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_icode_reg <= I_NOP;
      e_ifun_reg  <= 4'h0;
      e_val_a_reg <= '0;
      e_val_b_reg <= '0;
      e_val_c_reg <= '0;
      e_dst_e_reg <= RNONE;
      e_dst_m_reg <= RNONE;
    end else if (bus.E_bubble) begin
      e_icode_reg <= I_NOP;
      e_ifun_reg  <= 4'h0;
      e_val_a_reg <= '0;
      e_val_b_reg <= '0;
      e_val_c_reg <= '0;
      e_dst_e_reg <= RNONE;
      e_dst_m_reg <= RNONE;
    end else begin
      e_icode_reg <= bus.D_icode;
      e_ifun_reg  <= bus.D_ifun;
      e_val_a_reg <= bus.D_valA;
      e_val_b_reg <= bus.D_valB;
      e_val_c_reg <= bus.D_valC;
      e_dst_e_reg <= bus.D_dstE;
      e_dst_m_reg <= bus.D_dstM;
    end
  end

  // Operand and function select
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_fun;

  always_comb begin
    alu_a = '0;
    case (e_icode_reg)
      I_RRMOVQ, I_OPQ:             alu_a = e_val_a_reg;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = e_val_c_reg;
      I_CALL, I_PUSHQ:             alu_a = STACK_DEC;
      I_RET, I_POPQ:               alu_a = STACK_INC;
      default:                     alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (e_icode_reg)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
      I_PUSHQ, I_RET, I_POPQ: alu_b = e_val_b_reg;
      default:                alu_b = '0;
    endcase
  end

  assign alu_fun = (e_icode_reg == I_OPQ) ? e_ifun_reg : F_ADD;

  // ALU core and result flags
  logic [W-1:0] alu_r;
  logic         r_zf;
  logic         r_sf;
  logic         r_of;

  always_comb begin
    alu_r = '0;
    r_of  = 1'b0;
    case (alu_fun)
      F_ADD: begin
        alu_r = alu_b + alu_a;
        r_of  = (alu_a[W-1] == alu_b[W-1]) && (alu_r[W-1] != alu_a[W-1]);
      end
      F_SUB: begin
        alu_r = alu_b - alu_a;
        r_of  = (alu_a[W-1] != alu_b[W-1]) && (alu_r[W-1] != alu_b[W-1]);
      end
      F_AND:   alu_r = alu_b & alu_a;
      F_XOR:   alu_r = alu_b ^ alu_a;
      default: alu_r = '0;
    endcase
  end

  assign r_zf = (alu_r == '0);
  assign r_sf = alu_r[W-1];

  // Condition codes; an undefined OPQ function leaves them alone
  logic [2:0] cc_reg;
  logic [2:0] cc_next;
  logic       set_cc;

  assign set_cc  = (e_icode_reg == I_OPQ) && (e_ifun_reg <= F_XOR) && !bus.cc_hold;
  assign cc_next = set_cc ? {r_zf, r_sf, r_of} : cc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_reg <= 3'b100;
    end else begin
      cc_reg <= cc_next;
    end
  end

  // Jump/cmov condition sees the flags from before this instruction's own update
  logic cc_zf;
  logic cc_sf;
  logic cc_of;
  logic e_cnd;

  assign cc_zf = cc_reg[2];
  assign cc_sf = cc_reg[1];
  assign cc_of = cc_reg[0];

  always_comb begin
    e_cnd = 1'b0;
    case (e_ifun_reg)
      4'h0:    e_cnd = 1'b1;
      4'h1:    e_cnd = (cc_sf ^ cc_of) | cc_zf;
      4'h2:    e_cnd = cc_sf ^ cc_of;
      4'h3:    e_cnd = cc_zf;
      4'h4:    e_cnd = ~cc_zf;
      4'h5:    e_cnd = ~(cc_sf ^ cc_of);
      4'h6:    e_cnd = ~(cc_sf ^ cc_of) & ~cc_zf;
      default: e_cnd = 1'b0;
    endcase
  end

  logic [3:0] e_dst_e;
  assign e_dst_e = ((e_icode_reg == I_RRMOVQ) && !e_cnd) ? RNONE : e_dst_e_reg;

  // M pipeline register; a bubble loads the same value as reset
  logic [3:0]   m_icode_reg;
  logic         m_cnd_reg;
  logic [W-1:0] m_val_e_reg;
  logic [W-1:0] m_val_a_reg;
  logic [3:0]   m_dst_e_reg;
  logic [3:0]   m_dst_m_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_icode_reg <= I_NOP;
      m_cnd_reg   <= 1'b0;
      m_val_e_reg <= '0;
      m_val_a_reg <= '0;
      m_dst_e_reg <= RNONE;
      m_dst_m_reg <= RNONE;
    end else if (bus.M_bubble) begin
      m_icode_reg <= I_NOP;
      m_cnd_reg   <= 1'b0;
      m_val_e_reg <= '0;
      m_val_a_reg <= '0;
      m_dst_e_reg <= RNONE;
      m_dst_m_reg <= RNONE;
    end else begin
      m_icode_reg <= e_icode_reg;
      m_cnd_reg   <= e_cnd;
      m_val_e_reg <= alu_r;
      m_val_a_reg <= e_val_a_reg;
      m_dst_e_reg <= e_dst_e;
      m_dst_m_reg <= e_dst_m_reg;
    end
  end

  assign bus.e_valE  = alu_r;
  assign bus.e_dstE  = e_dst_e;
  assign bus.e_Cnd   = e_cnd;
  assign bus.M_icode = m_icode_reg;
  assign bus.M_Cnd   = m_cnd_reg;
  assign bus.M_valE  = m_val_e_reg;
  assign bus.M_valA  = m_val_a_reg;
  assign bus.M_dstE  = m_dst_e_reg;
  assign bus.M_dstM  = m_dst_m_reg;
  assign bus.cc      = cc_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed steps from the stage's documented scenarios followed by
// random instructions, all checked against a behavioural model of the E/CC/M state.
module tb_execute_stage;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  execute_stage_if bus ();

  execute_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: instruction held in E, condition codes, and M contents
  logic [3:0]  q_icode, q_ifun, q_dste, q_dstm;
  logic [63:0] q_a, q_b, q_c;
  logic [2:0]  q_cc;
  logic [3:0]  x_icode, x_dste, x_dstm;
  logic        x_cnd;
  logic [63:0] x_vale, x_vala;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // What one instruction does in the execute stage, derived from the ISA rules
  task automatic ref_execute(input logic [3:0] icode, input logic [3:0] ifun,
                             input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                             input logic [3:0] dste, input logic [2:0] cc,
                             output logic [63:0] vale, output logic cnd,
                             output logic [3:0] eff_dste, output logic wr,
                             output logic [2:0] flags);
    logic [63:0] opa, opb;
    logic [64:0] wide;
    logic        ovf, lt;
    opa = 64'd0;
    opb = 64'd0;
    ovf = 1'b0;
    if (icode == 4'h2 || icode == 4'h6) opa = a;
    else if (icode >= 4'h3 && icode <= 4'h5) opa = c;
    else if (icode == 4'h8 || icode == 4'hA) opa = 64'd0 - 64'd8;
    else if (icode == 4'h9 || icode == 4'hB) opa = 64'd8;
    if (icode >= 4'h4 && icode <= 4'hB && icode != 4'h7) opb = b;
    if (icode != 4'h6) begin
      vale = opb + opa;
    end else begin
      case (ifun)
        4'h0: begin
          wide = {opb[63], opb} + {opa[63], opa};
          vale = wide[63:0];
          ovf  = wide[64] != wide[63];
        end
        4'h1: begin
          wide = {opb[63], opb} - {opa[63], opa};
          vale = wide[63:0];
          ovf  = wide[64] != wide[63];
        end
        4'h2:    vale = opb & opa;
        4'h3:    vale = opb ^ opa;
        default: vale = 64'd0;
      endcase
    end
    wr    = (icode == 4'h6) && (ifun <= 4'h3);
    flags = {vale == 64'd0, vale[63], ovf};
    lt    = cc[1] != cc[0];
    case (ifun)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = lt || cc[2];
      4'h2:    cnd = lt;
      4'h3:    cnd = cc[2];
      4'h4:    cnd = !cc[2];
      4'h5:    cnd = !lt;
      4'h6:    cnd = !lt && !cc[2];
      default: cnd = 1'b0;
    endcase
    eff_dste = (icode == 4'h2 && !cnd) ? 4'hF : dste;
  endtask

  task automatic model_reset();
    q_icode = 4'h1; q_ifun = 4'h0; q_a = 64'd0; q_b = 64'd0; q_c = 64'd0;
    q_dste = 4'hF; q_dstm = 4'hF;
    q_cc = 3'b100;
    x_icode = 4'h1; x_cnd = 1'b0; x_vale = 64'd0; x_vala = 64'd0;
    x_dste = 4'hF; x_dstm = 4'hF;
  endtask

  task automatic check_all(input string tag);
    logic [63:0] v;
    logic        cn, wr;
    logic [3:0]  de;
    logic [2:0]  fl;
    ref_execute(q_icode, q_ifun, q_a, q_b, q_c, q_dste, q_cc, v, cn, de, wr, fl);
    chk({tag, ".e_valE"},  bus.e_valE,  v);
    chk({tag, ".e_dstE"},  bus.e_dstE,  de);
    chk({tag, ".e_Cnd"},   bus.e_Cnd,   cn);
    chk({tag, ".M_icode"}, bus.M_icode, x_icode);
    chk({tag, ".M_Cnd"},   bus.M_Cnd,   x_cnd);
    chk({tag, ".M_valE"},  bus.M_valE,  x_vale);
    chk({tag, ".M_valA"},  bus.M_valA,  x_vala);
    chk({tag, ".M_dstE"},  bus.M_dstE,  x_dste);
    chk({tag, ".M_dstM"},  bus.M_dstM,  x_dstm);
    chk({tag, ".cc"},      bus.cc,      q_cc);
  endtask

  // Drive one decode slot, advance one edge, update the model, then compare everything
  task automatic apply(input string tag, input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [3:0] dste, input logic [3:0] dstm,
                       input logic eb, input logic mb, input logic hold);
    logic [63:0] v;
    logic        cn, wr;
    logic [3:0]  de;
    logic [2:0]  fl;
    bus.D_icode = icode; bus.D_ifun = ifun;
    bus.D_valA = a; bus.D_valB = b; bus.D_valC = c;
    bus.D_dstE = dste; bus.D_dstM = dstm;
    bus.E_bubble = eb; bus.M_bubble = mb; bus.cc_hold = hold;
    @(posedge clk);
    ref_execute(q_icode, q_ifun, q_a, q_b, q_c, q_dste, q_cc, v, cn, de, wr, fl);
    if (mb) begin
      x_icode = 4'h1; x_cnd = 1'b0; x_vale = 64'd0; x_vala = 64'd0;
      x_dste = 4'hF; x_dstm = 4'hF;
    end else begin
      x_icode = q_icode; x_cnd = cn; x_vale = v; x_vala = q_a;
      x_dste = de; x_dstm = q_dstm;
    end
    if (wr && !hold) q_cc = fl;
    if (eb) begin
      q_icode = 4'h1; q_ifun = 4'h0; q_a = 64'd0; q_b = 64'd0; q_c = 64'd0;
      q_dste = 4'hF; q_dstm = 4'hF;
    end else begin
      q_icode = icode; q_ifun = ifun; q_a = a; q_b = b; q_c = c;
      q_dste = dste; q_dstm = dstm;
    end
    #1;
    check_all(tag);
    $display("step %s icode=%h ifun=%h eb=%0b mb=%0b hold=%0b e_valE=%h cc=%b",
             tag, icode, ifun, eb, mb, hold, bus.e_valE, bus.cc);
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] r;
    case ($urandom_range(0, 5))
      0:       r = 64'd0;
      1:       r = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       r = 64'h8000_0000_0000_0000;
      3:       r = 64'h7FFF_FFFF_FFFF_FFFF;
      4:       r = 64'($urandom_range(0, 300));
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    rst_n = 1'b0;
    bus.D_icode = 4'h1; bus.D_ifun = 4'h0;
    bus.D_valA = 64'd0; bus.D_valB = 64'd0; bus.D_valC = 64'd0;
    bus.D_dstE = 4'hF; bus.D_dstM = 4'hF;
    bus.E_bubble = 1'b0; bus.M_bubble = 1'b0; bus.cc_hold = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.cc_lit", bus.cc, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;

    // AND sets SF only, then a positive AND clears all flags
    apply("and1", 4'h6, 4'h2, MIN64, ONES, 64'd0, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("and1.valE_lit", bus.e_valE, MIN64);
    apply("and2", 4'h6, 4'h2, MAX64, MAX64, 64'd0, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("and2.valE_lit", bus.e_valE, MAX64);
    chk("and1.cc_lit", bus.cc, 3'b010);
    // Signed overflow on ADD and SUB
    apply("add_ovf", 4'h6, 4'h0, MAX64, MAX64, 64'd0, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("add_ovf.valE_lit", bus.e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("and2.cc_lit", bus.cc, 3'b000);
    apply("sub_ovf", 4'h6, 4'h1, 64'd1, MIN64, 64'd0, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("sub_ovf.valE_lit", bus.e_valE, MAX64);
    chk("add_ovf.cc_lit", bus.cc, 3'b011);
    apply("and3", 4'h6, 4'h2, MAX64, MAX64, 64'd0, 4'h4, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("sub_ovf.cc_lit", bus.cc, 3'b001);
    // cmovle not taken with cc=000, taken with cc=100
    apply("cmov_nt", 4'h2, 4'h1, 64'h1234, 64'd0, 64'd0, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("cmov_nt.cnd_lit", bus.e_Cnd, 1'b0);
    chk("cmov_nt.dstE_lit", bus.e_dstE, 4'hF);
    apply("xor_zero", 4'h6, 4'h3, 64'd5, 64'd5, 64'd0, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0);
    apply("cmov_t", 4'h2, 4'h1, 64'h1234, 64'd0, 64'd0, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("cmov_t.cc_lit", bus.cc, 3'b100);
    chk("cmov_t.cnd_lit", bus.e_Cnd, 1'b1);
    chk("cmov_t.dstE_lit", bus.e_dstE, 4'h3);
    // Stack pointer arithmetic leaves CC alone
    apply("pushq", 4'hA, 4'h0, 64'h77, 64'h100, 64'd0, 4'h4, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("pushq.valE_lit", bus.e_valE, 64'hF8);
    apply("popq", 4'hB, 4'h0, 64'hF8, 64'hF8, 64'd0, 4'h4, 4'h6, 1'b0, 1'b0, 1'b0);
    chk("popq.valE_lit", bus.e_valE, 64'h100);
    chk("popq.cc_lit", bus.cc, 3'b100);
    // XOR leaves E under cc_hold while both pipeline registers bubble
    apply("xor_held", 4'h6, 4'h3, 64'd3, 64'd5, 64'd0, 4'h7, 4'hF, 1'b0, 1'b0, 1'b0);
    apply("bubble2", 4'h6, 4'h0, 64'd9, 64'd9, 64'd9, 4'h8, 4'h9, 1'b1, 1'b1, 1'b1);
    chk("bubble2.cc_lit", bus.cc, 3'b100);
    chk("bubble2.M_icode_lit", bus.M_icode, 4'h1);
    chk("bubble2.M_dstE_lit", bus.M_dstE, 4'hF);
    apply("after_bub", 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("after_bub.M_icode_lit", bus.M_icode, 4'h1);
    chk("after_bub.M_valE_lit", bus.M_valE, 64'd0);
    chk("after_bub.M_dstE_lit", bus.M_dstE, 4'hF);
    // Load non-NOP state, then reset asynchronously between edges
    apply("pre_rst1", 4'h6, 4'h0, MIN64, MIN64, 64'd0, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0);
    apply("pre_rst2", 4'h5, 4'h0, 64'h55, 64'h40, 64'h10, 4'hF, 4'h3, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst.M_icode_lit", bus.M_icode, 4'h1);
    chk("async_rst.M_dstE_lit", bus.M_dstE, 4'hF);
    chk("async_rst.M_valE_lit", bus.M_valE, 64'd0);
    chk("async_rst.cc_lit", bus.cc, 3'b100);
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      logic [3:0] ic, fn;
      ic = 4'($urandom_range(0, 11));
      fn = 4'($urandom_range(0, 15));
      if (ic == 4'h6 && $urandom_range(0, 3) != 0) fn = 4'($urandom_range(0, 3));
      apply($sformatf("rnd%0d", i), ic, fn, rnd64(), rnd64(), rnd64(),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
